// File: rtl/cic_ctrl.sv
// -----------------------------------------------------------------------------
// cic_ctrl -- run/stop sequencer and output buffer for a CIC decimator.
//
// Generates the CIC input strobe (cic_en) once every DIV system clocks while a
// run is active, counts strobes into frames of R, and finishes a stopped run on
// a frame boundary so the decimator always sees whole output periods.  CIC
// output samples are captured into a single valid/ready holding register; a
// sample that arrives while the register is still occupied is dropped and the
// sticky ovf flag is raised.
//
// Optional feature (compile-time macro CIC_CTRL_SETTLE_EN):
//   defined   -> the first SETTLE CIC outputs after every accepted start are
//                discarded while the filter settles.
//   undefined -> no discard logic; every CIC output goes to the holding register.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no strobes; waiting for start (CIC outputs still drain)
// RUN      | strobing every DIV clocks; stop moves to STOPPING or IDLE
// STOPPING | strobing until the frame counter wraps, then IDLE
// -----------------------------------------------------------------------------
module cic_ctrl #(
    parameter int NOUT         = 16,
    parameter int SYS_CLK_FREQ = 6400_000,
    parameter int DEMOD_FREQ   = 16_000,
    parameter int SAMPLE_RATE  = 800,
    parameter int SETTLE       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    output logic            cic_en,
    input  logic            cic_valid,
    input  logic [NOUT-1:0] cic_dout,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [NOUT-1:0] m_data,
    output logic            busy,
    output logic            ovf
);

    localparam int DIV   = SYS_CLK_FREQ / DEMOD_FREQ;
    localparam int R     = DEMOD_FREQ / SAMPLE_RATE;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int R_W   = (R > 1) ? $clog2(R) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [R_W-1:0]   R_LAST   = R_W'(R - 1);

    // Reject parameter sets whose rates do not divide evenly.
    if ((SYS_CLK_FREQ % DEMOD_FREQ) != 0 || (DEMOD_FREQ % SAMPLE_RATE) != 0 ||
        DIV < 2 || R < 1 || SETTLE < 0) begin : g_bad_cfg
        $error("cic_ctrl: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [R_W-1:0]   frame_cnt;
    logic [R_W-1:0]   frame_nxt;
    logic             cic_en_nxt;
    logic             div_last;
    logic             frame_last;
    logic             start_ok;

    assign div_last   = (div_cnt == DIV_LAST);
    assign frame_last = (frame_cnt == R_LAST);
    // A start only counts in IDLE and only when stop is not asserted with it.
    assign start_ok   = (state == IDLE) && start && !stop;

    // Next-state, counter advance and registered strobe decode.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        frame_nxt = frame_cnt;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    div_nxt   = '0;
                    frame_nxt = '0;
                end
            end
            RUN: begin
                div_nxt = div_last ? '0 : div_cnt + DIV_W'(1);
                if (div_last) begin
                    frame_nxt = frame_last ? '0 : frame_cnt + R_W'(1);
                end
                if (stop) begin
                    // Already sitting on a frame boundary: nothing left to finish.
                    if (frame_cnt == '0 && div_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = STOPPING;
                    end
                end
            end
            STOPPING: begin
                div_nxt = div_last ? '0 : div_cnt + DIV_W'(1);
                if (div_last) begin
                    frame_nxt = frame_last ? '0 : frame_cnt + R_W'(1);
                end
                // The strobe that closes the frame is the last one of the run.
                if (div_last && frame_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == IDLE) begin
            div_nxt   = '0;
            frame_nxt = '0;
        end

        // Registering the decode of the next count keeps cic_en glitch-free and
        // aligned with the cycle where div_cnt == DIV-1.
        cic_en_nxt = (state_nxt != IDLE) && (div_nxt == DIV_LAST);
    end

    // Sequencer state, counters and strobe/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            frame_cnt <= '0;
            cic_en    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            frame_cnt <= frame_nxt;
            cic_en    <= cic_en_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    logic discard;
    logic load;
    logic drop;

`ifdef CIC_CTRL_SETTLE_EN
    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic [SET_W-1:0] discard_cnt;

    assign discard = cic_valid && (discard_cnt != '0);

    // Settle counter: reloaded by each accepted start, eats the first outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            discard_cnt <= '0;
        end else if (start_ok) begin
            discard_cnt <= SET_W'(SETTLE);
        end else if (discard) begin
            discard_cnt <= discard_cnt - SET_W'(1);
        end
    end
`else
    assign discard = 1'b0;
`endif

    assign load = cic_valid && !discard && (!m_valid || m_ready);
    assign drop = cic_valid && !discard && m_valid && !m_ready;

    // Holding register, handshake and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (load) begin
                m_data  <= cic_dout;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            // A drop in the same cycle as a start is the newer event and wins.
            if (drop) begin
                ovf <= 1'b1;
            end else if (start_ok) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_ctrl.sv
// Bench for cic_ctrl with DIV=4, R=4, SETTLE=2.
module tb_cic_ctrl;

    localparam int NOUT   = 16;
    localparam int DIV    = 4;
    localparam int R      = 4;
    localparam int SETTLE = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            cic_en;
    logic            cic_valid = 1'b0;
    logic [NOUT-1:0] cic_dout = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [NOUT-1:0] m_data;
    logic            busy;
    logic            ovf;

    cic_ctrl #(
        .NOUT(NOUT), .SYS_CLK_FREQ(80), .DEMOD_FREQ(20), .SAMPLE_RATE(5), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cic_en(cic_en),
        .cic_valid(cic_valid), .cic_dout(cic_dout), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    // Model: a run is described by cycles since start (k, first run cycle = 1)
    // and strobes issued so far (n); strobe when k is a multiple of DIV.
    bit              m_run = 0;
    bit              m_sr  = 0;
    int              m_k   = 0;
    int              m_n   = 0;
    int              m_d   = 0;
    bit              e_en = 0, e_busy = 0, e_mv = 0, e_ovf = 0;
    logic [NOUT-1:0] e_md = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic model_zero();
        m_run = 0; m_sr = 0; m_k = 0; m_n = 0; m_d = 0;
        e_en = 0; e_busy = 0; e_mv = 0; e_ovf = 0; e_md = '0;
    endtask

    // Advance one clock: model computes the next cycle from present inputs,
    // the DUT samples at the edge, and control returns 1 time unit later.
    task automatic cyc();
        bit run_n = m_run, sr_n = m_sr, mv_n = e_mv, ovf_n = e_ovf, en_c, ld;
        int k_n = m_k, n_n = m_n, d_n = m_d;
        logic [NOUT-1:0] md_n = e_md;
        bit disc = 0;
        bit acc_start = !m_run && start && !stop;

        en_c = m_run && (m_k % DIV == 0);
        if (!m_run) begin
            if (acc_start) begin
                run_n = 1; k_n = 1; n_n = 0; sr_n = 0;
            end
        end else begin
            n_n = m_n + (en_c ? 1 : 0);
            k_n = m_k + 1;
            if (m_sr) begin
                if (en_c && (n_n % R == 0)) run_n = 0;
            end else if (stop) begin
                if ((m_n % R == 0) && ((m_k - 1) % DIV == 0)) run_n = 0;
                else sr_n = 1;
            end
        end
        if (!run_n) begin k_n = 0; sr_n = 0; n_n = 0; end

`ifdef CIC_CTRL_SETTLE_EN
        disc = cic_valid && (m_d > 0);
        if (acc_start) d_n = SETTLE;
        else if (disc) d_n = m_d - 1;
`endif
        ld = cic_valid && !disc && (!e_mv || m_ready);
        if (ld) begin md_n = cic_dout; mv_n = 1; end
        else if (e_mv && m_ready) mv_n = 0;
        if (cic_valid && !disc && e_mv && !m_ready) ovf_n = 1;
        else if (acc_start) ovf_n = 0;

        @(posedge clk);
        if (rst) begin
            model_zero();
        end else begin
            m_run = run_n; m_sr = sr_n; m_k = k_n; m_n = n_n; m_d = d_n;
            e_md = md_n; e_mv = mv_n; e_ovf = ovf_n;
            e_busy = run_n;
            e_en = run_n && (k_n % DIV == 0);
        end
        cyc_cnt++;
        #1;
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc && busy; i++) cyc();
        chk("idle_timeout", busy, 0);
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_cic_en", cic_en, e_en);
        chk("cmp_busy", busy, e_busy);
        chk("cmp_m_valid", m_valid, e_mv);
        chk("cmp_m_data", m_data, e_md);
        chk("cmp_ovf", ovf, e_ovf);
    end

    int q[$];
    int strobe_lit[4] = '{4, 8, 12, 16};
    int cnt;
    logic [NOUT-1:0] lit_md;

    initial begin
        model_zero();
        repeat (3) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_cic_en", cic_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        cyc();

        // Strobe timing, start ignored in RUN, stop finishing on a frame.
        start = 1; cyc(); start = 0;
        for (int off = 1; off <= 22; off++) begin
            if (cic_en) q.push_back(off);
            if (off == 1)  chk("t1_busy_at1", busy, 1);
            if (off == 17) chk("t1_busy_at17", busy, 0);
            if (off == 6) start = 1;
            if (off == 9) stop = 1;
            cyc();
            start = 0; stop = 0;
        end
        chk("t1_strobe_count", q.size(), 4);
        for (int i = 0; i < 4 && i < q.size(); i++) chk("t1_strobe_cycle", q[i], strobe_lit[i]);

        // Settle discard with a ready consumer.
        m_ready = 1;
        start = 1; cyc(); start = 0;
        cic_valid = 1; cic_dout = 16'h0001; cyc();
`ifdef CIC_CTRL_SETTLE_EN
        chk("t2_mv_after1", m_valid, 0);
`else
        chk("t2_mv_after1", m_valid, 1);
        chk("t2_md_after1", m_data, 16'h0001);
`endif
        cic_dout = 16'h0002; cyc();
`ifdef CIC_CTRL_SETTLE_EN
        chk("t2_mv_after2", m_valid, 0);
`else
        chk("t2_md_after2", m_data, 16'h0002);
`endif
        cic_dout = 16'h0003; cyc(); cic_valid = 0;
        chk("t2_mv_after3", m_valid, 1);
        chk("t2_md_after3", m_data, 16'h0003);
        stop = 1; cyc(); stop = 0;
        wait_idle(40);

        // Overflow with a stalled consumer, sticky until the next start.
        m_ready = 0;
        start = 1; cyc(); start = 0;
        cic_valid = 1;
        cic_dout = 16'h0011; cyc();
        cic_dout = 16'h0012; cyc();
        cic_dout = 16'h0021; cyc();
        cic_dout = 16'h0022; cyc();
        cic_valid = 0;
`ifdef CIC_CTRL_SETTLE_EN
        lit_md = 16'h0021;
`else
        lit_md = 16'h0011;
`endif
        chk("t3_md_held", m_data, lit_md);
        chk("t3_mv_held", m_valid, 1);
        chk("t3_ovf_set", ovf, 1);
        m_ready = 1; cyc(); m_ready = 0;
        stop = 1; cyc(); stop = 0;
        wait_idle(40);
        chk("t3_ovf_sticky", ovf, 1);
        start = 1; cyc(); start = 0;
        chk("t3_ovf_cleared", ovf, 0);
        stop = 1; cyc(); stop = 0;
        chk("t3_boundary_stop_idle", busy, 0);

        // start+stop together and stop alone in IDLE are both no-ops.
        start = 1; stop = 1; cyc(); start = 0; stop = 0;
        chk("t4_busy_startstop", busy, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin if (cic_en) cnt++; cyc(); end
        chk("t4_no_strobe", cnt, 0);
        stop = 1; cyc(); stop = 0;
        chk("t4_busy_stop_idle", busy, 0);

        // CIC outputs drain while IDLE.
        m_ready = 1;
        cic_valid = 1;
        cic_dout = 16'h0055; cyc();
        cic_dout = 16'h0056; cyc();
        cic_dout = 16'h0057; cyc();
        cic_valid = 0;
        chk("t5_idle_md", m_data, 16'h0057);
        chk("t5_idle_mv", m_valid, 1);
        cyc();

        // Reset in the middle of a run, one cycle before a strobe would be due.
        m_ready = 0;
        start = 1; cyc(); start = 0;
        for (int off = 1; off < 7; off++) begin
            cic_valid = (off >= 2 && off <= 4);
            cic_dout = NOUT'(16'h0090 + off);
            cyc();
        end
        cic_valid = 0;
        chk("t6_busy_before_rst", busy, 1);
        chk("t6_mv_before_rst", m_valid, 1);
        #2;
        rst = 1;
        model_zero();
        #1;
        chk("t6_rst_cic_en", cic_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_m_valid", m_valid, 0);
        chk("t6_rst_m_data", m_data, 0);
        cyc(); cyc();
        rst = 0;
        cyc();
        chk("t6_idle_after_rst", busy, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin if (cic_en) cnt++; cyc(); end
        chk("t6_no_strobe_after_rst", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_ctrl.md
CIC_CTRL -- requirements
Module: cic_ctrl

Interface
REQ-001 SHALL have parameter NOUT, default 16, width of the CIC output sample.
REQ-002 SHALL have parameter SYS_CLK_FREQ, default 6400_000, system clock in Hz.
REQ-003 SHALL have parameter DEMOD_FREQ, default 16_000, CIC input strobe rate in Hz; DIV = SYS_CLK_FREQ/DEMOD_FREQ (400).
REQ-004 SHALL have parameter SAMPLE_RATE, default 800, CIC output rate in Hz; R = DEMOD_FREQ/SAMPLE_RATE (20).
REQ-005 SHALL have parameter SETTLE, default 2, number of CIC outputs discarded after each start.
REQ-006 clk  in  1  system clock, rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 start  in  1  one-cycle pulse; begins a run.
REQ-009 stop  in  1  one-cycle pulse; ends the run at the next frame boundary.
REQ-010 cic_en  out  1  one-cycle input strobe to the CIC en.
REQ-011 cic_valid  in  1  CIC output-valid pulse.
REQ-012 cic_dout  in  NOUT  signed CIC output sample.
REQ-013 m_valid / m_ready / m_data[NOUT]  out/in/out  downstream valid-ready sample port.
REQ-014 busy  out  1  high when state is not IDLE.
REQ-015 ovf  out  1  sticky flag; a sample was dropped because the holding register was full.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, STOPPING; busy = (state != IDLE).
REQ-017 IDLE: start with stop low -> RUN; clears div counter, frame counter and ovf; loads discard counter with SETTLE.
REQ-018 IDLE: start and stop in the same cycle -> stay IDLE; stop has priority.
REQ-019 RUN/STOPPING: div counter counts 0..DIV-1 and wraps; cic_en is high exactly in the cycle where div counter == DIV-1.
REQ-020 First cic_en SHALL be asserted DIV cycles after the start cycle, then every DIV cycles.
REQ-021 Frame counter SHALL count issued cic_en pulses modulo R.
REQ-022 RUN: stop -> STOPPING, except when frame counter == 0 and div counter == 0, which goes directly to IDLE.
REQ-023 STOPPING: continue strobing; the cic_en that wraps the frame counter to 0 is the last, then IDLE next cycle.
REQ-024 start SHALL be ignored in RUN and STOPPING; stop SHALL be ignored in IDLE.
REQ-025 cic_valid SHALL be accepted in every state, including IDLE, so in-flight CIC outputs drain.
REQ-026 On accepted cic_valid with discard counter > 0: decrement; sample dropped; ovf unaffected.
REQ-027 Otherwise, if m_valid is low or m_ready is high: m_data <= cic_dout, m_valid <= 1 next cycle.
REQ-028 Otherwise: sample dropped, m_data kept, ovf <= 1 (sticky until next accepted start).
REQ-029 m_valid && m_ready without a new load -> m_valid <= 0; m_data SHALL hold while m_valid is high and m_ready is low.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-031 SYS_CLK_FREQ % DEMOD_FREQ and DEMOD_FREQ % SAMPLE_RATE SHALL be 0; DIV >= 2, R >= 1.

Reset
REQ-032 rst high SHALL immediately force: state IDLE, all counters 0, cic_en 0, m_valid 0, m_data 0, ovf 0, busy 0.
REQ-033 Reset mid-run SHALL abort without a further cic_en; the first cycle after rst deasserts is IDLE.

Configuration
REQ-034 Macro CIC_CTRL_SETTLE_EN defined: the SETTLE discard of REQ-017/REQ-026 is active.
REQ-035 CIC_CTRL_SETTLE_EN undefined: discard logic is absent; every cic_valid goes to REQ-027/REQ-028; SETTLE is unused.

Verification (DIV=4, R=4, SETTLE=2: SYS_CLK_FREQ=80, DEMOD_FREQ=20, SAMPLE_RATE=5)
REQ-036 start at cycle 0 -> cic_en at cycles 4, 8, 12, ...; busy high from cycle 1.
REQ-037 stop at cycle 9 (2 strobes issued) -> strobes at 12 and 16 only; busy low at cycle 17.
REQ-038 cic_valid with dout 0x0001, 0x0002, 0x0003, m_ready=1 -> 0x0001 and 0x0002 discarded; m_data=0x0003 with m_valid=1. Without the macro, all three appear.
REQ-039 m_ready=0 with two post-settle samples -> m_data holds the first, ovf=1; the next start clears ovf.
REQ-040 start and stop in the same cycle in IDLE -> no cic_en, busy stays 0; rst pulse mid-RUN -> cic_en, m_valid and busy at 0 immediately.
